seq_block_verilog: RTL and testbench



---
 rtl/seq_block_verilog.sv | 43 ++++
 tb/tb_seq_block_verilog.sv | 65 ++++++
 2 files changed

// File: rtl/seq_block_verilog.sv
// seq_block_verilog: free-running 6,3,5,7,2,1 sequence generator; SEQ_BLOCK_ONEHOT_EN selects one-hot state
module seq_block_verilog (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] Y
);
`ifdef SEQ_BLOCK_ONEHOT_EN
    localparam int W = 7;
    typedef enum logic [W-1:0] {
        IDLE = 7'b0000001,
        S0   = 7'b0000010,
        S1   = 7'b0000100,
        S2   = 7'b0001000,
        S3   = 7'b0010000,
        S4   = 7'b0100000,
        S5   = 7'b1000000
    } state_t;
`else
    localparam int W = 3;
    typedef enum logic [W-1:0] {IDLE, S0, S1, S2, S3, S4, S5} state_t;
`endif
    // plain vector so illegal encodings are representable and fall through to IDLE
    logic [W-1:0] state = IDLE;
    logic [2:0]   y_q   = 3'd0;
    assign Y = y_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            y_q   <= 3'd0;
        end else begin
            case (state)
                IDLE:    begin state <= S0;   y_q <= 3'd6; end
                S0:      begin state <= S1;   y_q <= 3'd3; end
                S1:      begin state <= S2;   y_q <= 3'd5; end
                S2:      begin state <= S3;   y_q <= 3'd7; end
                S3:      begin state <= S4;   y_q <= 3'd2; end
                S4:      begin state <= S5;   y_q <= 3'd1; end
                S5:      begin state <= S0;   y_q <= 3'd6; end
                default: begin state <= IDLE; y_q <= 3'd0; end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_block_verilog.sv
// tb_seq_block_verilog: reference-model bench for the 6,3,5,7,2,1 sequence generator
module tb_seq_block_verilog;
`ifdef SEQ_BLOCK_ONEHOT_EN
    localparam int W = 7;
    localparam logic [W-1:0] ILL = 7'b0000011;
`else
    localparam int W = 3;
    localparam logic [W-1:0] ILL = 3'd7;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] y;
    logic [2:0] seq [6] = '{3'd6, 3'd3, 3'd5, 3'd7, 3'd2, 3'd1};
    int         n = 0;
    int         errors = 0;
    int         checks = 0;
    logic [W-1:0] ill = ILL;

    seq_block_verilog dut (.clk(clk), .rst(rst), .Y(y));

    always #100 clk = ~clk;

    // n counts edges since IDLE; n<=0 means Y should read 0
    function automatic logic [2:0] expv(int k);
        return (k <= 0) ? 3'd0 : seq[(k - 1) % 6];
    endfunction

    task automatic chk(input string tag);
        checks++;
        assert (y === expv(n)) else begin
            errors++;
            $error("FAIL %s: Y=%0d expected %0d (edge %0d)", tag, y, expv(n), n);
        end
    endtask

    task automatic step(input logic r, input string tag);
        rst = r;
        @(posedge clk);
        n = r ? 0 : n + 1;
        #1 chk({tag, "_post"});
        @(negedge clk);
        chk(tag);
    endtask

    initial begin
        #50 chk("powerup");
        for (int i = 0; i < 21; i++) step(1'b0, "run");
        for (int i = 0; i < 6 && expv(n) != 3'd5; i++) step(1'b0, "seek5");
        step(1'b1, "rst_mid");
        step(1'b0, "after_rst");
        step(1'b0, "after_rst2");
        for (int i = 0; i < 4; i++) step(1'b1, "rst_hold");
        step(1'b0, "release");
        step(1'b0, "release2");
        force dut.state = ill;
        #1 release dut.state;
        n = -1;
        step(1'b0, "illegal");
        step(1'b0, "recover");
        step(1'b0, "recover2");
        for (int i = 0; i < 80; i++) step($urandom_range(0, 7) == 0, "rand");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
